systolic_5x5_ctrl: RTL and testbench

- Sequencer for the 5x5 output-stationary systolic array.
- Accepts unskewed fmap/weight beat vectors over a valid/ready stream for a configured reduction length K.
- Applies row/column skew and generates the diagonal mul_en wave, per-row str_en store strobes and per-PE pe_en clock-gate enables.
- Sits between the operand buffers and the array; one job = one K-length accumulation followed by a row-by-row store.

---
 rtl/systolic_pkg.sv | 19 +
 rtl/skew_delay_line.sv | 27 ++
 rtl/systolic_5x5_ctrl.sv | 111 +++++++++++
 tb/tb_systolic_5x5_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and PE indexing for the 5x5 systolic sequencer.
package systolic_pkg;
    localparam int D_BW  = 8;
    localparam int ROWS  = 5;
    localparam int COLS  = 5;
    localparam int K_BW  = 10;
    localparam int NDIAG = ROWS + COLS - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_STORE = 2'd3
    } state_e;

    function automatic int pe_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction
endpackage

// File: rtl/skew_delay_line.sv
// N-deep operand delay line; the head stage loads the beat only when it is accepted.
module skew_delay_line #(
    parameter int N = 1,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [N-1:0][W-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            // bubbles enter as zeros so idle slots never carry stale operands
            sr_q[0] <= load_i ? d_i : '0;
            for (int i = 1; i < N; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[N-1];
endmodule

// File: rtl/systolic_5x5_ctrl.sv
// Job sequencer for the output-stationary array: skews operands, drives the diagonal MAC wave,
// then strobes each row's store/clear once the last beat has left the array.
module systolic_5x5_ctrl #(
    parameter int D_BW = systolic_pkg::D_BW,
    parameter int ROWS = systolic_pkg::ROWS,
    parameter int COLS = systolic_pkg::COLS,
    parameter int K_BW = systolic_pkg::K_BW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [K_BW-1:0]      cfg_k,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [D_BW*ROWS-1:0] in_fmap,
    input  logic [D_BW*COLS-1:0] in_weight,
    output logic [D_BW*ROWS-1:0] o_fmap,
    output logic [D_BW*COLS-1:0] o_weight,
    output logic [ROWS+COLS-2:0] mul_en,
    output logic [ROWS-1:0]      str_en,
    output logic [ROWS*COLS-1:0] pe_en
);
    import systolic_pkg::*;

    localparam int ND = ROWS + COLS - 1;
    localparam int RW = $clog2(ROWS);

    state_e          state_q, state_d;
    logic [K_BW-1:0] k_q, cnt_q;
    logic [RW-1:0]   row_q;
    logic [ND-1:0]   acc_q;
    logic            done_q;
    logic            accept;

    assign accept = in_valid & in_ready;
    assign mul_en = acc_q;
    assign done   = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && cfg_k != '0)                 state_d = ST_LOAD;
            ST_LOAD:  if (accept && cnt_q == k_q - 1'b1)        state_d = ST_DRAIN;
            // leave one cycle early: only the last diagonal may still be set, and it clears now
            ST_DRAIN: if (acc_q[ND-2:0] == '0)                  state_d = ST_STORE;
            ST_STORE: if (row_q == RW'(ROWS - 1))               state_d = ST_IDLE;
            default:                                            state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        in_ready = (state_q == ST_LOAD) && (cnt_q < k_q);
        str_en   = '0;
        if (state_q == ST_STORE) str_en = ROWS'(1) << row_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q    <= '0;
            cnt_q  <= '0;
            row_q  <= '0;
            acc_q  <= '0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= {acc_q[ND-2:0], accept};
            done_q <= (state_q == ST_STORE) && (row_q == RW'(ROWS - 1));
            if (state_q == ST_IDLE && start && cfg_k != '0) begin
                k_q   <= cfg_k;
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == ST_STORE) row_q <= row_q + 1'b1;
            else                     row_q <= '0;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_fmap
        skew_delay_line #(.N(r + 1), .W(D_BW)) u_dly (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (accept),
            .d_i    (in_fmap[r*D_BW +: D_BW]),
            .q_o    (o_fmap[r*D_BW +: D_BW])
        );
    end

    for (genvar c = 0; c < COLS; c++) begin : g_wgt
        skew_delay_line #(.N(c + 1), .W(D_BW)) u_dly (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (accept),
            .d_i    (in_weight[c*D_BW +: D_BW]),
            .q_o    (o_weight[c*D_BW +: D_BW])
        );
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_pe_r
        for (genvar c = 0; c < COLS; c++) begin : g_pe_c
            assign pe_en[pe_idx(r, c, COLS)] = mul_en[r + c] | str_en[r];
        end
    end
endmodule

// File: tb/tb_systolic_5x5_ctrl.sv
// Directed bench for systolic_5x5_ctrl with a beat-history scoreboard checked every cycle.
module tb_systolic_5x5_ctrl;
    import systolic_pkg::*;

    localparam int FW = D_BW * ROWS;
    localparam int WW = D_BW * COLS;

    logic                  clk = 1'b0;
    logic                  rst_n, start, in_valid, busy, done, in_ready;
    logic [K_BW-1:0]       cfg_k;
    logic [FW-1:0]         in_fmap, o_fmap;
    logic [WW-1:0]         in_weight, o_weight;
    logic [NDIAG-1:0]      mul_en;
    logic [ROWS-1:0]       str_en;
    logic [ROWS*COLS-1:0]  pe_en;

    typedef struct packed {
        logic          acc;
        logic [FW-1:0] fm;
        logic [WW-1:0] wt;
    } beat_t;

    beat_t           hist[$];
    int              n_assert = 0, n_fail = 0;
    int              cyc = 0, store_at = -100;
    int              t0, n, first_m8, done_at;
    logic            m_busy, m_load;
    logic [K_BW-1:0] m_k, m_cnt;
    logic [5:0]      pat = 6'b101101;

    systolic_5x5_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_k     (cfg_k),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmap   (in_fmap),
        .in_weight (in_weight),
        .o_fmap    (o_fmap),
        .o_weight  (o_weight),
        .mul_en    (mul_en),
        .str_en    (str_en),
        .pe_en     (pe_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        beat_t z;
        z = '0;
        hist.delete();
        for (int i = 0; i < NDIAG; i++) hist.push_front(z);
        m_busy = 1'b0; m_load = 1'b0; m_k = '0; m_cnt = '0;
        store_at = -100;
    endtask

    // Expected outputs: the operand/flag for diagonal d, row r or column c is the beat taken d/r/c+1 cycles ago.
    task automatic check_outputs();
        logic [NDIAG-1:0]     em;
        logic [ROWS-1:0]      es;
        logic [FW-1:0]        ef;
        logic [WW-1:0]        ew;
        logic [ROWS*COLS-1:0] ep;
        em = '0; es = '0; ef = '0; ew = '0; ep = '0;
        for (int d = 0; d < NDIAG; d++) em[d] = hist[d].acc;
        for (int r = 0; r < ROWS; r++) ef[r*D_BW +: D_BW] = hist[r].fm[r*D_BW +: D_BW];
        for (int c = 0; c < COLS; c++) ew[c*D_BW +: D_BW] = hist[c].wt[c*D_BW +: D_BW];
        if (cyc >= store_at && cyc < store_at + ROWS) es[cyc - store_at] = 1'b1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) ep[r*COLS + c] = em[r + c] | es[r];
        chk("mul_en",   64'(mul_en),   64'(em));
        chk("o_fmap",   64'(o_fmap),   64'(ef));
        chk("o_weight", 64'(o_weight), 64'(ew));
        chk("str_en",   64'(str_en),   64'(es));
        chk("pe_en",    64'(pe_en),    64'(ep));
        chk("done",     64'(done),     64'(cyc == store_at + ROWS));
        chk("busy",     64'(busy),     64'(m_busy));
        chk("in_ready", 64'(in_ready), 64'(m_load && (m_cnt < m_k)));
    endtask

    task automatic step();
        beat_t e;
        logic  acc;
        acc = in_valid && m_load && (m_cnt < m_k);
        if (start && !m_busy && cfg_k != '0) begin
            m_busy = 1'b1; m_load = 1'b1; m_k = cfg_k; m_cnt = '0;
        end
        if (acc) begin
            m_cnt = m_cnt + 1'b1;
            if (m_cnt == m_k) begin
                m_load   = 1'b0;
                store_at = cyc + ROWS + COLS;
            end
        end
        e.acc = acc;
        e.fm  = acc ? in_fmap : '0;
        e.wt  = acc ? in_weight : '0;
        hist.push_front(e);
        if (hist.size() > NDIAG) void'(hist.pop_back());
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == store_at + ROWS) m_busy = 1'b0;
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_k = '0; in_valid = 1'b0;
        in_fmap = '0; in_weight = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mul_en",   64'(mul_en),   64'(0));
        chk("rst_o_fmap",   64'(o_fmap),   64'(0));
        chk("rst_o_weight", 64'(o_weight), 64'(0));
        chk("rst_str_en",   64'(str_en),   64'(0));
        chk("rst_pe_en",    64'(pe_en),    64'(0));
        chk("rst_busy",     64'(busy),     64'(0));
        chk("rst_done",     64'(done),     64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        step(); step();

        // K=3, valid held high, start re-pulsed during LOAD
        start = 1'b1; cfg_k = 10'd3; step();
        t0 = cyc; first_m8 = -1; done_at = -1; in_valid = 1'b1;
        for (int i = 0; i < 40 && done_at < 0; i++) begin
            in_fmap   = (i == 0) ? 40'h14_13_12_11_10 : FW'({$urandom(), $urandom()});
            in_weight = (i == 0) ? 40'h24_23_22_21_20 : WW'({$urandom(), $urandom()});
            start     = (i == 1);
            cfg_k     = (i == 1) ? 10'd7 : 10'd0;
            step();
            n = cyc - t0;
            if (mul_en[NDIAG-1] && first_m8 < 0) first_m8 = n;
            if (done) done_at = n;
            if (n >= 1 && n <= ROWS)
                chk($sformatf("beat0_fmap_r%0d", n - 1), 64'(o_fmap[(n-1)*D_BW +: D_BW]), 64'(16 + n - 1));
            if (n >= 1 && n <= COLS)
                chk($sformatf("beat0_wgt_c%0d", n - 1), 64'(o_weight[(n-1)*D_BW +: D_BW]), 64'(32 + n - 1));
            if (n == 12) chk("k3_str_row0", 64'(str_en), 64'(1));
        end
        start = 1'b0; in_valid = 1'b0;
        chk("k3_mul8_first", 64'(first_m8), 64'(9));
        chk("k3_done_cycle", 64'(done_at), 64'(17));

        // K=4 with valid pattern 1,0,1,1,0,1
        start = 1'b1; cfg_k = 10'd4; step(); start = 1'b0;
        t0 = cyc; done_at = -1;
        for (int i = 0; i < 40 && done_at < 0; i++) begin
            in_valid  = (i < 6) ? pat[i] : 1'b0;
            in_fmap   = FW'({$urandom(), $urandom()});
            in_weight = WW'({$urandom(), $urandom()});
            if (i == 2) in_fmap[2*D_BW +: D_BW] = 8'h5A;
            step();
            n = cyc - t0;
            if (done) done_at = n;
            if (n == 4 || n == 7)
                chk($sformatf("bubble_fmap_r2_n%0d", n), 64'(o_fmap[2*D_BW +: D_BW]), 64'(0));
            if (n == 5) chk("fmap_r2_5A", 64'(o_fmap[2*D_BW +: D_BW]), 64'(8'h5A));
            if (n >= 4 && n <= 9)
                chk($sformatf("mul3_pat_n%0d", n), 64'(mul_en[3]), 64'(pat[n-4]));
        end
        in_valid = 1'b0;
        chk("k4_done_cycle", 64'(done_at), 64'(20));

        // start with K=0 is ignored
        start = 1'b1; cfg_k = 10'd0; step(); start = 1'b0; step();
        chk("k0_busy", 64'(busy), 64'(0));
        chk("k0_done", 64'(done), 64'(0));

        // asynchronous reset in the middle of DRAIN
        start = 1'b1; cfg_k = 10'd2; step(); start = 1'b0;
        in_valid = 1'b1; step(); step(); in_valid = 1'b0;
        repeat (4) step();
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_mul_en",   64'(mul_en),   64'(0));
        chk("rstmid_o_fmap",   64'(o_fmap),   64'(0));
        chk("rstmid_o_weight", 64'(o_weight), 64'(0));
        chk("rstmid_pe_en",    64'(pe_en),    64'(0));
        chk("rstmid_busy",     64'(busy),     64'(0));
        chk("rstmid_done",     64'(done),     64'(0));
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        // K=1; the beat offered alongside start must not be taken
        start = 1'b1; cfg_k = 10'd1; in_valid = 1'b1;
        in_fmap = FW'({$urandom(), $urandom()}); in_weight = WW'({$urandom(), $urandom()});
        step(); start = 1'b0;
        chk("start_beat_not_taken", 64'(mul_en[0]), 64'(0));
        t0 = cyc; done_at = -1;
        for (int i = 0; i < 30 && done_at < 0; i++) begin
            in_valid  = (i == 0);
            in_fmap   = FW'({$urandom(), $urandom()});
            in_weight = WW'({$urandom(), $urandom()});
            step();
            n = cyc - t0;
            if (done) done_at = n;
            if (n >= 1 && n <= 15)
                chk($sformatf("pe23_n%0d", n), 64'(pe_en[2*COLS + 3]), 64'(n == 6 || n == 12));
        end
        in_valid = 1'b0;
        chk("k1_done_cycle", 64'(done_at), 64'(15));
        repeat (3) step();
        chk("idle_pe_en", 64'(pe_en), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
